// File: rtl/time_set_controller_if.sv
// Button, live-time and load bus between the time-set sequencer and its surroundings.
interface time_set_controller_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_dec;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes;
  logic       run_en;
  logic       load;
  logic [4:0] load_hours;
  logic [5:0] load_minutes;
  logic [5:0] load_seconds;
  logic [1:0] edit_field;
  logic       blink;

  modport master (
    output btn_mode, btn_inc, btn_dec, cur_hours, cur_minutes,
    input  run_en, load, load_hours, load_minutes, load_seconds, edit_field, blink
  );

  modport slave (
    input  btn_mode, btn_inc, btn_dec, cur_hours, cur_minutes,
    output run_en, load, load_hours, load_minutes, load_seconds, edit_field, blink
  );
endinterface

// File: rtl/time_set_controller.sv
// Button-driven hour/minute editor for the 24 h counter chain: debounce, auto-repeat,
// edit FSM with idle timeout, blink phase and a one-cycle load strobe on commit.
module time_set_controller #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int HOLD_CYC     = 50_000_000,
  parameter int REPEAT_CYC   = 25_000_000,
  parameter int BLINK_CYC    = 25_000_000,
  parameter int TIMEOUT_CYC  = 1_000_000_000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  time_set_controller_if.slave  io_bus
);

  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_SET_HR  = 2'b01;
  localparam logic [1:0] ST_SET_MIN = 2'b10;
  localparam logic [1:0] ST_COMMIT  = 2'b11;

  localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int RP_W  = $clog2(((HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC) + 1);
  localparam int BL_W  = $clog2(BLINK_CYC + 1);
  localparam int ID_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [RP_W-1:0] HOLD_FIRE = RP_W'(HOLD_CYC);
  localparam logic [RP_W-1:0] REP_FIRE  = RP_W'(REPEAT_CYC);
  localparam logic [BL_W-1:0] BL_LAST   = BL_W'(BLINK_CYC - 1);
  localparam logic [ID_W-1:0] ID_LAST   = ID_W'(TIMEOUT_CYC - 1);

  // Button index: 0 mode, 1 inc, 2 dec
  logic [2:0]      w_raw;
  logic [2:0]      r_sync1;
  logic [2:0]      r_sync2;
  logic [2:0]      r_level;
  logic [2:0]      r_level_d;
  logic [DB_W-1:0] r_db_cnt [3];
  logic [2:0]      w_rise;

  logic [RP_W-1:0] r_rep_cnt [2];
  logic [1:0]      r_rep_on;
  logic [1:0]      w_fire;

  logic            w_mode_p;
  logic            w_inc_p;
  logic            w_dec_p;
  logic            w_any_p;
  logic            w_step_up;
  logic            w_step_dn;
  logic            w_timeout;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [5:0]      r_edit_hr;
  logic [5:0]      r_edit_min;
  logic [5:0]      w_hr_nxt;
  logic [5:0]      w_min_nxt;
  logic [5:0]      w_cur_hr;
  logic [5:0]      w_cur_min;
  logic [ID_W-1:0] r_idle;
  logic [BL_W-1:0] r_blink_cnt;
  logic            r_blink;
  logic            r_run_en;
  logic            r_load;
  logic [4:0]      r_load_hr;
  logic [5:0]      r_load_min;
  logic            w_in_edit_nxt;
  logic            w_blink_restart;

  assign w_raw = {io_bus.btn_dec, io_bus.btn_inc, io_bus.btn_mode};

  // Two-flop synchroniser, stability counter and accepted level per button.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1   <= 3'b000;
      r_sync2   <= 3'b000;
      r_level   <= 3'b000;
      r_level_d <= 3'b000;
      for (int b = 0; b < 3; b++) r_db_cnt[b] <= '0;
    end else begin
      r_sync1   <= w_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      for (int b = 0; b < 3; b++) begin
        if (r_sync2[b] == r_level[b]) begin
          r_db_cnt[b] <= '0;
        end else if (r_db_cnt[b] == DB_LAST) begin
          r_db_cnt[b] <= '0;
          r_level[b]  <= r_sync2[b];
        end else begin
          r_db_cnt[b] <= r_db_cnt[b] + DB_W'(1);
        end
      end
    end
  end

  assign w_rise = r_level & ~r_level_d;

  // Auto-repeat fires first after HOLD_CYC held cycles, then every REPEAT_CYC.
  always_comb begin
    w_fire = 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (r_rep_on[k]) begin
        w_fire[k] = r_level[k+1] && (r_rep_cnt[k] == REP_FIRE);
      end else begin
        w_fire[k] = r_level[k+1] && (r_rep_cnt[k] == HOLD_FIRE);
      end
    end
  end

  // Held-time counters for inc/dec, cleared whenever the button is released.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rep_on <= 2'b00;
      for (int k = 0; k < 2; k++) r_rep_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!r_level[k+1]) begin
          r_rep_cnt[k] <= '0;
          r_rep_on[k]  <= 1'b0;
        end else if (w_fire[k]) begin
          r_rep_cnt[k] <= RP_W'(1);
          r_rep_on[k]  <= 1'b1;
        end else begin
          r_rep_cnt[k] <= r_rep_cnt[k] + RP_W'(1);
        end
      end
    end
  end

  assign w_mode_p  = w_rise[0];
  assign w_inc_p   = w_rise[1] | w_fire[0];
  assign w_dec_p   = w_rise[2] | w_fire[1];
  assign w_any_p   = w_mode_p | w_inc_p | w_dec_p;
  assign w_step_up = w_inc_p & ~w_dec_p & ~w_mode_p;
  assign w_step_dn = w_dec_p & ~w_inc_p & ~w_mode_p;
  assign w_timeout = (r_idle == ID_LAST);
  assign w_cur_hr  = ({1'b0, io_bus.cur_hours} > 6'd23) ? 6'd0 : {1'b0, io_bus.cur_hours};
  assign w_cur_min = (io_bus.cur_minutes > 6'd59) ? 6'd0 : io_bus.cur_minutes;

  // Edit FSM next-state and edit-value arithmetic; a pulse outranks a same-cycle timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_hr_nxt    = r_edit_hr;
    w_min_nxt   = r_edit_min;
    case (r_state)
      ST_RUN: begin
        if (w_mode_p) begin
          w_state_nxt = ST_SET_HR;
          w_hr_nxt    = w_cur_hr;
          w_min_nxt   = w_cur_min;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_SET_HR: begin
        if (w_mode_p) begin
          w_state_nxt = ST_SET_MIN;
        end else if (w_step_up) begin
          w_hr_nxt = (r_edit_hr >= 6'd23) ? 6'd0 : r_edit_hr + 6'd1;
        end else if (w_step_dn) begin
          w_hr_nxt = (r_edit_hr == 6'd0) ? 6'd23 : r_edit_hr - 6'd1;
        end else if (w_timeout) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_SET_HR;
        end
      end
      ST_SET_MIN: begin
        if (w_mode_p) begin
          w_state_nxt = ST_COMMIT;
        end else if (w_step_up) begin
          w_min_nxt = (r_edit_min >= 6'd59) ? 6'd0 : r_edit_min + 6'd1;
        end else if (w_step_dn) begin
          w_min_nxt = (r_edit_min == 6'd0) ? 6'd59 : r_edit_min - 6'd1;
        end else if (w_timeout) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_SET_MIN;
        end
      end
      ST_COMMIT: w_state_nxt = ST_RUN;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  assign w_in_edit_nxt   = (w_state_nxt == ST_SET_HR) || (w_state_nxt == ST_SET_MIN);
  assign w_blink_restart = (r_state != w_state_nxt);

  // State, edit registers, idle timer and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_RUN;
      r_edit_hr   <= 6'd0;
      r_edit_min  <= 6'd0;
      r_idle      <= '0;
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
      r_run_en    <= 1'b1;
      r_load      <= 1'b0;
      r_load_hr   <= 5'd0;
      r_load_min  <= 6'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_edit_hr  <= w_hr_nxt;
      r_edit_min <= w_min_nxt;
      r_run_en   <= (w_state_nxt == ST_RUN);
      r_load     <= (w_state_nxt == ST_COMMIT);
      if (w_state_nxt == ST_COMMIT) begin
        r_load_hr  <= w_hr_nxt[4:0];
        r_load_min <= w_min_nxt;
      end else begin
        r_load_hr  <= r_load_hr;
        r_load_min <= r_load_min;
      end
      if (!w_in_edit_nxt || w_any_p) begin
        r_idle <= '0;
      end else begin
        r_idle <= r_idle + ID_W'(1);
      end
      // Field changes (entry to SET_HR, SET_HR->SET_MIN) restart the blink phase.
      if (!w_in_edit_nxt || w_blink_restart) begin
        r_blink_cnt <= '0;
        r_blink     <= 1'b0;
      end else if (r_blink_cnt == BL_LAST) begin
        r_blink_cnt <= '0;
        r_blink     <= ~r_blink;
      end else begin
        r_blink_cnt <= r_blink_cnt + BL_W'(1);
      end
    end
  end

  assign io_bus.run_en       = r_run_en;
  assign io_bus.load         = r_load;
  assign io_bus.load_hours   = r_load_hr;
  assign io_bus.load_minutes = r_load_min;
  assign io_bus.load_seconds = 6'd0;
  assign io_bus.edit_field   = r_state;
  assign io_bus.blink        = r_blink;

endmodule

// File: tb/tb_time_set_controller.sv
// Self-checking bench for time_set_controller: directed scenarios plus randomized edit
// sessions compared against a field/value model driven by press durations.
module tb_time_set_controller;
  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;
  localparam int BLK  = 5;
  localparam int TMO  = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  time_set_controller_if bus ();

  time_set_controller #(
    .DEBOUNCE_CYC(DEB), .HOLD_CYC(HOLD), .REPEAT_CYC(REP),
    .BLINK_CYC(BLK), .TIMEOUT_CYC(TMO)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Observed load strobes
  int         load_cycles = 0;
  logic [4:0] cap_h = 5'd0;
  logic [5:0] cap_m = 6'd0;
  logic [5:0] cap_s = 6'd0;

  always @(negedge clk) begin
    if (bus.load === 1'b1) begin
      load_cycles <= load_cycles + 1;
      cap_h       <= bus.load_hours;
      cap_m       <= bus.load_minutes;
      cap_s       <= bus.load_seconds;
    end
  end

  // Reference model: field 0 RUN, 1 hours, 2 minutes
  int m_field = 0;
  int m_hr = 0;
  int m_min = 0;
  int m_loads = 0;
  int m_load_h = 0;
  int m_load_m = 0;

  function automatic int nsteps(input int held);
    if (held > HOLD) return 2 + (held - 1 - HOLD) / REP;
    return 1;
  endfunction

  task automatic press(input logic m, input logic i, input logic d, input int hold);
    int n;
    @(negedge clk);
    bus.btn_mode = m;
    bus.btn_inc  = i;
    bus.btn_dec  = d;
    repeat (hold) @(negedge clk);
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.btn_dec  = 1'b0;
    repeat (12) @(negedge clk);
    n = nsteps(hold);
    if (m) begin
      if (m_field == 0) begin
        m_hr    = (bus.cur_hours > 5'd23) ? 0 : int'(bus.cur_hours);
        m_min   = (bus.cur_minutes > 6'd59) ? 0 : int'(bus.cur_minutes);
        m_field = 1;
      end else if (m_field == 1) begin
        m_field = 2;
      end else begin
        m_field  = 0;
        m_loads  = m_loads + 1;
        m_load_h = m_hr;
        m_load_m = m_min;
      end
    end else if (i && d) begin
      m_field = m_field;
    end else if (m_field == 1) begin
      if (i) m_hr = (m_hr + n) % 24;
      if (d) m_hr = (((m_hr - n) % 24) + 24) % 24;
    end else if (m_field == 2) begin
      if (i) m_min = (m_min + n) % 60;
      if (d) m_min = (((m_min - n) % 60) + 60) % 60;
    end
  endtask

  task automatic test_reset();
    bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; bus.btn_dec = 1'b0;
    bus.cur_hours = 5'd0; bus.cur_minutes = 6'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.run_en !== 1'b1) begin errors++; $display("FAIL reset_run_en: got %b want 1", bus.run_en); end
    checks++; if (bus.load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b want 0", bus.load); end
    checks++; if (bus.edit_field !== 2'b00) begin errors++; $display("FAIL reset_field: got %b want 00", bus.edit_field); end
    checks++; if (bus.blink !== 1'b0) begin errors++; $display("FAIL reset_blink: got %b want 0", bus.blink); end
    checks++; if (bus.load_hours !== 5'd0 || bus.load_minutes !== 6'd0 || bus.load_seconds !== 6'd0) begin
      errors++; $display("FAIL reset_payload: got %0d:%0d:%0d want 0:0:0", bus.load_hours, bus.load_minutes, bus.load_seconds);
    end
  endtask

  task automatic test_enter_edit();
    bus.cur_hours = 5'd12; bus.cur_minutes = 6'd34;
    press(1'b1, 1'b0, 1'b0, 6);
    checks++; if (bus.edit_field !== 2'(m_field)) begin errors++; $display("FAIL enter_field: got %b want %0d", bus.edit_field, m_field); end
    checks++; if (bus.run_en !== 1'b0) begin errors++; $display("FAIL enter_run_en: got %b want 0", bus.run_en); end
    bus.cur_hours = 5'd3; bus.cur_minutes = 6'd7;
    press(1'b1, 1'b0, 1'b0, 6);
    checks++; if (bus.edit_field !== 2'b10) begin errors++; $display("FAIL enter_min_field: got %b want 10", bus.edit_field); end
    press(1'b1, 1'b0, 1'b0, 6);
    checks++; if (load_cycles !== m_loads || cap_h !== 5'(m_load_h) || cap_m !== 6'(m_load_m) || cap_s !== 6'd0) begin
      errors++; $display("FAIL enter_commit: loads=%0d %0d:%0d:%0d want loads=%0d %0d:%0d:0", load_cycles, cap_h, cap_m, cap_s, m_loads, m_load_h, m_load_m);
    end
    checks++; if (bus.run_en !== 1'b1 || bus.edit_field !== 2'b00) begin
      errors++; $display("FAIL enter_back_run: run_en=%b field=%b want 1/00", bus.run_en, bus.edit_field);
    end
  endtask

  task automatic test_wrap();
    bus.cur_hours = 5'd23; bus.cur_minutes = 6'd59;
    press(1'b1, 1'b0, 1'b0, 6);
    press(1'b0, 1'b1, 1'b0, 6);
    press(1'b0, 1'b0, 1'b1, 6);
    press(1'b1, 1'b0, 1'b0, 6);
    press(1'b0, 1'b1, 1'b0, 6);
    press(1'b1, 1'b0, 1'b0, 6);
    checks++; if (load_cycles !== m_loads || cap_h !== 5'd23 || cap_m !== 6'd0 || cap_s !== 6'd0) begin
      errors++; $display("FAIL wrap_commit: loads=%0d %0d:%0d:%0d want loads=%0d 23:0:0", load_cycles, cap_h, cap_m, cap_s, m_loads);
    end
    checks++; if (bus.run_en !== 1'b1) begin errors++; $display("FAIL wrap_run_en: got %b want 1", bus.run_en); end
  endtask

  task automatic test_blink();
    int toggles;
    logic prev;
    bus.cur_hours = 5'd1; bus.cur_minutes = 6'd2;
    press(1'b1, 1'b0, 1'b0, 6);
    for (int pass = 0; pass < 2; pass++) begin
      toggles = 0;
      prev = bus.blink;
      for (int c = 0; c < 4 * BLK; c++) begin
        @(negedge clk);
        if (bus.blink !== prev) toggles++;
        prev = bus.blink;
      end
      checks++; if (toggles !== 4) begin errors++; $display("FAIL blink_toggles: field %0d got %0d want 4", pass + 1, toggles); end
      press(1'b1, 1'b0, 1'b0, 6);
    end
    checks++; if (bus.blink !== 1'b0 || bus.edit_field !== 2'b00) begin
      errors++; $display("FAIL blink_run: blink=%b field=%b want 0/00", bus.blink, bus.edit_field);
    end
  endtask

  task automatic test_bounce_repeat();
    bus.cur_hours = 5'd5; bus.cur_minutes = 6'd10;
    press(1'b1, 1'b0, 1'b0, 6);
    @(negedge clk);
    bus.btn_inc = 1'b1;
    repeat (3) @(negedge clk);
    bus.btn_inc = 1'b0;
    repeat (12) @(negedge clk);
    press(1'b0, 1'b1, 1'b0, 40);
    press(1'b1, 1'b0, 1'b0, 6);
    press(1'b1, 1'b0, 1'b0, 6);
    checks++; if (load_cycles !== m_loads || cap_h !== 5'd9 || cap_m !== 6'd10) begin
      errors++; $display("FAIL bounce_repeat: loads=%0d %0d:%0d want loads=%0d 9:10", load_cycles, cap_h, cap_m, m_loads);
    end
  endtask

  task automatic test_simultaneous();
    bus.cur_hours = 5'd8; bus.cur_minutes = 6'd20;
    press(1'b1, 1'b0, 1'b0, 6);
    press(1'b0, 1'b1, 1'b1, 8);
    checks++; if (bus.edit_field !== 2'b01) begin errors++; $display("FAIL simul_incdec_field: got %b want 01", bus.edit_field); end
    press(1'b1, 1'b1, 1'b0, 8);
    checks++; if (bus.edit_field !== 2'b10) begin errors++; $display("FAIL simul_mode_inc_field: got %b want 10", bus.edit_field); end
    press(1'b1, 1'b0, 1'b0, 6);
    checks++; if (load_cycles !== m_loads || cap_h !== 5'd8 || cap_m !== 6'd20) begin
      errors++; $display("FAIL simul_commit: loads=%0d %0d:%0d want loads=%0d 8:20", load_cycles, cap_h, cap_m, m_loads);
    end
  endtask

  task automatic test_random();
    int nops;
    logic up;
    for (int r = 0; r < 6; r++) begin
      bus.cur_hours   = 5'($urandom_range(0, 23));
      bus.cur_minutes = 6'($urandom_range(0, 59));
      press(1'b1, 1'b0, 1'b0, 6);
      for (int f = 0; f < 2; f++) begin
        nops = $urandom_range(0, 3);
        for (int k = 0; k < nops; k++) begin
          up = 1'($urandom_range(0, 1));
          press(up, 1'b0, 1'b0, 0);
        end
      end
    end
  endtask

  task automatic test_random_edit();
    int nops;
    int hold;
    logic up;
    for (int r = 0; r < 6; r++) begin
      bus.cur_hours   = 5'($urandom_range(0, 23));
      bus.cur_minutes = 6'($urandom_range(0, 59));
      press(1'b1, 1'b0, 1'b0, 6);
      for (int f = 0; f < 2; f++) begin
        nops = $urandom_range(1, 3);
        for (int k = 0; k < nops; k++) begin
          up   = 1'($urandom_range(0, 1));
          hold = $urandom_range(5, 50);
          press(1'b0, up, ~up, hold);
        end
        checks++; if (bus.edit_field !== 2'(m_field)) begin
          errors++; $display("FAIL rand_field: round %0d got %b want %0d", r, bus.edit_field, m_field);
        end
        press(1'b1, 1'b0, 1'b0, 6);
      end
      checks++; if (load_cycles !== m_loads || cap_h !== 5'(m_load_h) || cap_m !== 6'(m_load_m) || cap_s !== 6'd0) begin
        errors++; $display("FAIL rand_commit: round %0d loads=%0d %0d:%0d:%0d want loads=%0d %0d:%0d:0", r, load_cycles, cap_h, cap_m, cap_s, m_loads, m_load_h, m_load_m);
      end
    end
  endtask

  task automatic test_timeout();
    bus.cur_hours = 5'd3; bus.cur_minutes = 6'd4;
    press(1'b1, 1'b0, 1'b0, 6);
    press(1'b1, 1'b0, 1'b0, 6);
    repeat (150) @(negedge clk);
    checks++; if (bus.edit_field !== 2'b10) begin errors++; $display("FAIL timeout_early: got %b want 10", bus.edit_field); end
    repeat (100) @(negedge clk);
    m_field = 0;
    checks++; if (bus.edit_field !== 2'b00 || bus.run_en !== 1'b1) begin
      errors++; $display("FAIL timeout_run: field=%b run_en=%b want 00/1", bus.edit_field, bus.run_en);
    end
    checks++; if (load_cycles !== m_loads) begin errors++; $display("FAIL timeout_no_load: got %0d loads want %0d", load_cycles, m_loads); end
  endtask

  task automatic test_reset_mid();
    bus.cur_hours = 5'd6; bus.cur_minutes = 6'd6;
    press(1'b1, 1'b0, 1'b0, 6);
    checks++; if (bus.edit_field !== 2'b01) begin errors++; $display("FAIL rstmid_pre: got %b want 01", bus.edit_field); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_field = 0;
    checks++; if (bus.run_en !== 1'b1 || bus.edit_field !== 2'b00 || bus.load !== 1'b0) begin
      errors++; $display("FAIL rstmid_async: run_en=%b field=%b load=%b want 1/00/0", bus.run_en, bus.edit_field, bus.load);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (load_cycles !== m_loads || bus.run_en !== 1'b1) begin
      errors++; $display("FAIL rstmid_after: loads=%0d run_en=%b want %0d/1", load_cycles, bus.run_en, m_loads);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_enter_edit();
    test_wrap();
    test_blink();
    test_bounce_repeat();
    test_simultaneous();
    test_random_edit();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
